// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory stage
//
// Purpose: I/O window word offsets, TCTRL bit positions and the default
// ID register value, shared by data_mem_ctrl and mmio_timer.
// Ports: none (package).

package dmem_pkg;

  // Word offsets inside the I/O window at the bottom of the address space.
  localparam int ADDR_ID       = 0;
  localparam int ADDR_GPIO_OUT = 1;
  localparam int ADDR_GPIO_IN  = 2;
  localparam int ADDR_TCTRL    = 3;
  localparam int ADDR_TLOAD    = 4;
  localparam int ADDR_TCOUNT   = 5;

  // TCTRL bit positions.
  localparam int BIT_EN   = 0;
  localparam int BIT_AUTO = 1;
  localparam int BIT_EXP  = 2;

  // Value returned by the read-only ID register unless overridden.
  localparam logic [15:0] ID_VALUE_DEFAULT = 16'hC0DE;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - datapath-to-data-memory bus
//
// Purpose: groups the datapath's data-memory signals.
// Signals:
//   we     write enable from the datapath
//   addr   word address (ADDR_W bits)
//   wdata  write data (DATA_W bits)
//   rdata  read data, combinational from addr
// Modports: master (datapath side), slave (memory side).

interface data_mem_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/data_mem_ctrl_mmio_timer.sv
// rtl/data_mem_ctrl_mmio_timer.sv - prescaled down-counting timer with sticky expiry
//
// Purpose: holds TCTRL/TLOAD/TCOUNT and the prescaler; raises irq when the
// count is found at zero on a tick.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   wrCtrl      write strobe for TCTRL (from the top-level decode)
//   wrLoad      write strobe for TLOAD
//   wrCount     write strobe for TCOUNT
//   wdata       CPU write data
//   ctrl        TCTRL value {EXPIRED, AUTO, EN}
//   tload       TLOAD value
//   tcount      TCOUNT value
//   irq         sticky EXPIRED level

module mmio_timer
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrCtrl,
  input  logic              wrLoad,
  input  logic              wrCount,
  input  logic [DATA_W-1:0] wdata,
  output logic [2:0]        ctrl,
  output logic [DATA_W-1:0] tload,
  output logic [DATA_W-1:0] tcount,
  output logic              irq
);

  // PRESCALE of 1 still needs a 1-bit counter so the tick compare is legal.
  localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;
  logic            en;
  logic            autoReload;
  logic            expired;
  logic            tick;
  logic            expire;

  assign tick   = en && (presc == PS_MAX);
  assign expire = tick && (tcount == '0);

  // Held at zero while disabled, so an EN 0->1 write always starts a fresh
  // PRESCALE-clock interval.
  always_ff @(posedge clk) begin
    if (reset || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      autoReload <= 1'b0;
      expired    <= 1'b0;
      tload      <= '0;
      tcount     <= '0;
    end else begin
      // CPU write of EN/AUTO wins over the one-shot hardware EN clear.
      if (wrCtrl) begin
        en         <= wdata[BIT_EN];
        autoReload <= wdata[BIT_AUTO];
      end else if (expire && !autoReload) begin
        en <= 1'b0;
      end

      // Setting EXPIRED wins over a simultaneous write-1-to-clear.
      if (expire) begin
        expired <= 1'b1;
      end else if (wrCtrl && wdata[BIT_EXP]) begin
        expired <= 1'b0;
      end

      if (wrLoad) begin
        tload <= wdata;
      end

      // CPU write of TCOUNT wins over decrement or reload.
      if (wrCount) begin
        tcount <= wdata;
      end else if (tick) begin
        if (tcount != '0) begin
          tcount <= tcount - DATA_W'(1);
        end else if (autoReload) begin
          tcount <= tload;
        end
      end
    end
  end

  always_comb begin
    ctrl           = '0;
    ctrl[BIT_EN]   = en;
    ctrl[BIT_AUTO] = autoReload;
    ctrl[BIT_EXP]  = expired;
  end

  assign irq = expired;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data RAM plus I/O window (ID, GPIO, timer)
//
// Purpose: data-memory stage behind the CPU datapath. Addresses below
// IO_WORDS hit the I/O registers, everything above is RAM (including the
// stack at the top of the space). Reads are combinational and side-effect
// free; writes land on the rising edge.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   bus         data_mem_ctrl_if.slave: we, addr, wdata in; rdata out
//   gpio_in     asynchronous external inputs (synchronised here)
//   gpio_out    registered GPIO outputs
//   timer_irq   level interrupt, equal to the sticky EXPIRED bit

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int              ADDR_W   = 10,
  parameter int              DATA_W   = 16,
  parameter int              IO_WORDS = 16,
  parameter int              GPIO_W   = 8,
  parameter int              PRESCALE = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(ID_VALUE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_ctrl_if.slave    bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int RAM_LO = IO_WORDS;
  localparam int RAM_HI = (1 << ADDR_W) - 1;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic isIo;
  logic wrGpioOut;
  logic wrCtrl;
  logic wrLoad;
  logic wrCount;

  assign isIo      = bus.addr < ADDR_W'(IO_WORDS);
  assign wrGpioOut = bus.we && (bus.addr == ADDR_W'(ADDR_GPIO_OUT));
  assign wrCtrl    = bus.we && (bus.addr == ADDR_W'(ADDR_TCTRL));
  assign wrLoad    = bus.we && (bus.addr == ADDR_W'(ADDR_TLOAD));
  assign wrCount   = bus.we && (bus.addr == ADDR_W'(ADDR_TCOUNT));

  // ------------------------------------------------------------------
  // Data RAM: indexed directly by address, so only the RAM range exists.
  // Not cleared by reset; writes during reset are dropped.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] mem [RAM_LO:RAM_HI];
  logic [DATA_W-1:0] ramData;

  always_ff @(posedge clk) begin
    if (!reset && bus.we && !isIo) begin
      mem[bus.addr] <= bus.wdata;
    end
  end

  assign ramData = mem[bus.addr];

  // ------------------------------------------------------------------
  // GPIO: output register and 2-flop input synchroniser
  // ------------------------------------------------------------------
  logic [GPIO_W-1:0] gpioOutReg;
  logic [GPIO_W-1:0] gpioSync1;
  logic [GPIO_W-1:0] gpioSync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpioOutReg <= '0;
      gpioSync1  <= '0;
      gpioSync2  <= '0;
    end else begin
      if (wrGpioOut) begin
        gpioOutReg <= bus.wdata[GPIO_W-1:0];
      end
      gpioSync1 <= gpio_in;
      gpioSync2 <= gpioSync1;
    end
  end

  assign gpio_out = gpioOutReg;

  // ------------------------------------------------------------------
  // Timer
  // ------------------------------------------------------------------
  logic [2:0]        timerCtrl;
  logic [DATA_W-1:0] timerLoad;
  logic [DATA_W-1:0] timerCount;
  logic              timerIrq;

  mmio_timer #(
    .DATA_W   (DATA_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .wrCtrl  (wrCtrl),
    .wrLoad  (wrLoad),
    .wrCount (wrCount),
    .wdata   (bus.wdata),
    .ctrl    (timerCtrl),
    .tload   (timerLoad),
    .tcount  (timerCount),
    .irq     (timerIrq)
  );

  assign timer_irq = timerIrq;

  // ------------------------------------------------------------------
  // Read mux: purely combinational, no read side effects, because the
  // datapath parks on address 0 whenever it is idle.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] readData;

  always_comb begin
    readData = '0;
    if (!isIo) begin
      readData = ramData;
    end else begin
      case (bus.addr)
        ADDR_W'(ADDR_ID):       readData = ID_VALUE;
        ADDR_W'(ADDR_GPIO_OUT): readData = DATA_W'(gpioOutReg);
        ADDR_W'(ADDR_GPIO_IN):  readData = DATA_W'(gpioSync2);
        ADDR_W'(ADDR_TCTRL):    readData = DATA_W'(timerCtrl);
        ADDR_W'(ADDR_TLOAD):    readData = timerLoad;
        ADDR_W'(ADDR_TCOUNT):   readData = timerCount;
        default:                readData = '0;
      endcase
    end
  end

  assign bus.rdata = readData;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl

module tb_data_mem_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  data_mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // mid-cycle, well away from the edge.
  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [15:0] d);
    bus.addr = a; #1;
    d = bus.rdata;
  endtask

  task automatic wait_irq(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      if (timer_irq) seen = 1'b1;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Table of write-then-read vectors.
  typedef struct {
    bit          doWrite;
    logic [9:0]  wAddr;
    logic [15:0] wData;
    logic [9:0]  rAddr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic addVec(input bit w, input logic [9:0] wa, input logic [15:0] wd,
                        input logic [9:0] ra, input logic [15:0] e);
    vec_t v;
    v.doWrite = w; v.wAddr = wa; v.wData = wd; v.rAddr = ra; v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference model for the random phase (timer kept disabled).
  logic [15:0] ramM [int];
  int          ramAddrs[$];
  logic [7:0]  gpM;
  logic [15:0] tloadM;
  logic [15:0] tcountM;
  logic        autoM;
  logic [7:0]  gpInM;

  function automatic logic [15:0] expRead(input logic [9:0] a);
    if (a >= 10'd16) return ramM[int'(a)];
    case (a)
      10'd0:   return 16'hC0DE;
      10'd1:   return {8'h00, gpM};
      10'd2:   return {8'h00, gpInM};
      10'd3:   return {14'b0, autoM, 1'b0};
      10'd4:   return tloadM;
      10'd5:   return tcountM;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic modelWrite(input logic [9:0] a, input logic [15:0] d);
    if (a >= 10'd16) begin
      if (!ramM.exists(int'(a))) ramAddrs.push_back(int'(a));
      ramM[int'(a)] = d;
    end else begin
      case (a)
        10'd1: gpM = d[7:0];
        10'd3: autoM = d[1];
        10'd4: tloadM = d;
        10'd5: tcountM = d;
        default: ;
      endcase
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    bit          seen;
    int          e0;

    reset = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; gpio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    rd(10'h1, r); check("reset_gpio_out_reg", r, 16'h0);
    rd(10'h3, r); check("reset_tctrl", r, 16'h0);
    rd(10'h4, r); check("reset_tload", r, 16'h0);
    rd(10'h5, r); check("reset_tcount", r, 16'h0);
    check("reset_gpio_out_pin", gpio_out, 8'h00);
    check("reset_irq", timer_irq, 1'b0);

    // Table-driven vectors
    addVec(1, 10'h3FE, 16'h1234, 10'h3FE, 16'h1234);
    addVec(0, 10'h000, 16'h0000, 10'h000, 16'hC0DE);
    addVec(1, 10'h000, 16'hFFFF, 10'h000, 16'hC0DE);
    addVec(1, 10'h001, 16'hFFA5, 10'h001, 16'h00A5);
    addVec(1, 10'h007, 16'hFFFF, 10'h007, 16'h0000);
    addVec(1, 10'h00F, 16'h1234, 10'h00F, 16'h0000);
    addVec(1, 10'h010, 16'hBEEF, 10'h010, 16'hBEEF);
    addVec(1, 10'h003, 16'hFFF8, 10'h003, 16'h0000);
    addVec(1, 10'h004, 16'h0ABC, 10'h004, 16'h0ABC);
    addVec(1, 10'h002, 16'h5555, 10'h002, 16'h0000);
    addVec(1, 10'h3FF, 16'h7777, 10'h3FF, 16'h7777);
    addVec(0, 10'h000, 16'h0000, 10'h3FE, 16'h1234);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doWrite) wr(vecs[i].wAddr, vecs[i].wData);
      else begin @(posedge clk); #1; end
      rd(vecs[i].rAddr, r);
      check($sformatf("vec%0d_addr%0h", i, vecs[i].rAddr), r, vecs[i].exp);
    end
    check("gpio_out_pin_a5", gpio_out, 8'hA5);

    // GPIO input synchroniser: visible after two edges
    gpio_in = 8'h3C;
    rd(10'h2, r); check("gpio_in_before_edge", r, 16'h0000);
    @(posedge clk); #1;
    rd(10'h2, r); check("gpio_in_after_1_edge", r, 16'h0000);
    @(posedge clk); #1;
    rd(10'h2, r); check("gpio_in_after_2_edges", r, 16'h003C);

    // One-shot timer
    wr(10'h5, 16'd2);
    wr(10'h3, 16'h0001);
    e0 = cyc;
    wait_irq(40, seen);
    check("oneshot_irq_seen", seen, 1'b1);
    check("oneshot_irq_latency", cyc - e0, 12);
    rd(10'h3, r); check("oneshot_tctrl", r, 16'h0004);
    rd(10'h5, r); check("oneshot_tcount", r, 16'h0000);
    repeat (8) @(posedge clk);
    #1 rd(10'h5, r); check("oneshot_tcount_stays0", r, 16'h0000);

    // Auto-reload
    wr(10'h3, 16'h0004);
    check("clear_irq", timer_irq, 1'b0);
    wr(10'h4, 16'd3);
    wr(10'h5, 16'd3);
    wr(10'h3, 16'h0003);
    e0 = cyc;
    wait_irq(40, seen);
    check("auto_first_expiry", cyc - e0, 16);
    wr(10'h3, 16'h0007);
    check("auto_clear_irq", timer_irq, 1'b0);
    rd(10'h3, r); check("auto_tctrl_after_clear", r, 16'h0003);
    wait_irq(40, seen);
    check("auto_second_expiry", cyc - e0, 32);
    wr(10'h3, 16'h0007);
    check("auto_clear_irq2", timer_irq, 1'b0);
    step_to(e0 + 47);
    wr(10'h3, 16'h0007);
    check("expiry_beats_clear_irq", timer_irq, 1'b1);
    rd(10'h3, r); check("expiry_beats_clear_tctrl", r, 16'h0007);

    // TCOUNT write on a tick edge wins; next tick decrements it
    step_to(e0 + 55);
    wr(10'h5, 16'h0050);
    rd(10'h5, r); check("collision_tcount", r, 16'h0050);
    step_to(e0 + 60);
    rd(10'h5, r); check("post_collision_decrement", r, 16'h004F);

    // Reset mid-count, with a RAM write attempted in the reset cycle
    wr(10'h5, 16'd5);
    reset = 1'b1; bus.we = 1'b1; bus.addr = 10'h3FF; bus.wdata = 16'hDEAD;
    @(posedge clk); #1;
    reset = 1'b0; bus.we = 1'b0;
    rd(10'h1, r); check("rst_gpio_out_reg", r, 16'h0);
    rd(10'h3, r); check("rst_tctrl", r, 16'h0);
    rd(10'h5, r); check("rst_tcount", r, 16'h0);
    check("rst_gpio_out_pin", gpio_out, 8'h00);
    check("rst_irq", timer_irq, 1'b0);
    rd(10'h3FE, r); check("rst_ram_3fe_kept", r, 16'h1234);
    rd(10'h3FF, r); check("rst_ram_write_suppressed", r, 16'h7777);
    repeat (20) @(posedge clk);
    #1 rd(10'h5, r); check("rst_timer_stopped", r, 16'h0);
    check("rst_irq_stays_low", timer_irq, 1'b0);

    // Randomized phase against the reference model
    gpM = 8'h00; tloadM = '0; tcountM = '0; autoM = 1'b0;
    gpio_in = 8'($urandom); gpInM = gpio_in;
    repeat (3) @(posedge clk);
    #1;
    modelWrite(10'h3FE, 16'h1234);
    modelWrite(10'h3FF, 16'h7777);
    modelWrite(10'h010, 16'hBEEF);
    for (int i = 0; i < 300; i++) begin
      int          sel;
      logic [9:0]  a;
      logic [15:0] d;
      sel = $urandom_range(0, 9);
      d   = 16'($urandom);
      if (sel < 4) begin
        a = 10'($urandom_range(16, 1023));
        wr(a, d); modelWrite(a, d);
      end else if (sel < 6) begin
        a = 10'(ramAddrs[$urandom_range(0, ramAddrs.size() - 1)]);
        @(posedge clk); #1;
      end else begin
        a = 10'($urandom_range(0, 15));
        if (a == 10'd3) d[0] = 1'b0;
        if (sel < 9) begin
          wr(a, d); modelWrite(a, d);
        end else begin
          @(posedge clk); #1;
        end
      end
      rd(a, r);
      check($sformatf("rand%0d_addr%0h", i, a), r, expRead(a));
      check($sformatf("rand%0d_gpio_out", i), gpio_out, gpM);
    end
    check("rand_irq_low", timer_irq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
